srb_rd_sched: RTL and testbench
===============================

// Module: srb_rd_sched
// PURPOSE
//  Read scheduler for the sparse read buffer (SRB) in the ISU. It accepts read requests (SRB slot idx plus
//  consumer tag) into a small collapsing pending queue. It issues the oldest request whose SRB entry is
//  valid, so service is out of order across slots. It registers the SRB response into a 1-deep output stage.
//  Sits directly downstream of the SRB, driving its r_req/r_rsp ports and consuming entry_valid.
// PARAMETERS
//  DATA_WIDTH  32  SRB entry data width
//  SRB_DEPTH   8   SRB entries; IDX_W = $clog2(SRB_DEPTH)
//  TAG_W       4   consumer tag width, carried opaquely
//  PQ_DEPTH    4   pending-queue slots; CNT_W = $clog2(PQ_DEPTH+1)
// PORTS
//  clk              in   1           clock; single clock domain
//  rst_n            in   1           asynchronous active-low reset
//  flush            in   1           synchronous flush of pending queue and output stage
//  req_valid        in   1           read request valid
//  req_ready        out  1           request accepted
//  req_idx          in   IDX_W       SRB slot to read
//  req_tag          in   TAG_W       consumer tag
//  srb_r_req_valid  out  1           to SRB r_req_valid
//  srb_r_req_idx    out  IDX_W       to SRB r_req_idx
//  srb_r_req_ready  in   1           from SRB r_req_ready
//  srb_r_rsp_valid  in   1           from SRB (combinational in same cycle as r_req)
//  srb_r_rsp_data   in   DATA_WIDTH  from SRB
//  srb_r_rsp_ready  out  1           to SRB r_rsp_ready
//  srb_entry_valid  in   SRB_DEPTH   SRB per-slot valid bits
//  out_valid        out  1           registered response valid
//  out_ready        in   1           downstream ready
//  out_data         out  DATA_WIDTH  response data
//  out_tag          out  TAG_W       tag of the serviced request
//  out_idx          out  IDX_W       slot of the serviced request
//  pend_cnt         out  CNT_W       occupied pending slots
// BEHAVIOUR
//  Reset: pend_cnt=0, all slot valids=0, out_valid=0, out_data/out_tag/out_idx=0, srb_r_req_valid=0,
//   req_ready=1.
//  Pending queue: slots 0..PQ_DEPTH-1, each holding {idx,tag}. Slot 0 is the oldest; occupied slots are
//   contiguous.
//  Enqueue: a request is accepted when req_valid & req_ready. req_ready = (pend_cnt<PQ_DEPTH) & ~flush.
//   The same-cycle dequeue is not credited to req_ready.
//  Eligibility: slot k is eligible iff occupied & srb_entry_valid[slot_k.idx]. The selected slot is the
//   lowest eligible k (fixed priority = age).
//  Issue: srb_r_req_valid = any eligible & ~flush; srb_r_req_idx = selected idx.
//  Response ready: srb_r_rsp_ready = (~out_valid | out_ready) & ~flush.
//  Handshake: hsk = srb_r_rsp_valid & srb_r_rsp_ready. Issue and handshake complete in one cycle
//   (SRB is combinational).
//  On hsk in cycle t:
//   - capture {data,tag,idx} into the output stage; out_valid=1 at t+1;
//   - remove the selected slot; younger slots shift down one position at t+1.
//  Latency: request accepted at t enters the queue at t+1; no bypass. Earliest issue is t+1; earliest
//   out_valid is t+2.
//  Simultaneous enqueue+dequeue: the new entry is written at position pend_cnt-1 after the collapse.
//   pend_cnt is unchanged; age order is preserved.
//  Output stage: out_* hold stable while out_valid & ~out_ready. out_valid clears on out_ready unless
//   hsk reloads it in the same cycle, giving full throughput of 1 per cycle.
//  Duplicate idx: two slots may name the same idx. Only the oldest issues; SRB clears the entry, so the
//   younger waits until the slot is rewritten.
//  flush=1: at the next edge pend_cnt=0, all slots invalid, out_valid=0. No hsk and no enqueue occur that
//   cycle.
//  Async reset mid-operation returns all state to reset values immediately. No partial response is emitted.
//  pend_cnt saturates at PQ_DEPTH by construction; it never underflows.
// TESTING
//  1 Basic: entry_valid[3]=1; req idx=3 tag=5 at t -> srb_r_req_valid at t+1 with idx 3;
//    out_valid at t+2 with SRB data[3], tag 5; pend_cnt 1->0.
//  2 OOO: enqueue idx2/tag0 then idx5/tag1; entry_valid=8'b0010_0000 -> tag1 out first.
//    Then set bit 2 -> tag0 out.
//  3 Full: 4 requests, entry_valid=0 -> pend_cnt=4, req_ready=0, 5th request held.
//    Set one valid bit -> req_ready=1 the cycle after the handshake.
//  4 Backpressure: out_ready=0 with out_valid=1 -> srb_r_rsp_ready=0, no hsk, out_data stable.
//    out_ready=1 -> hsk in the same cycle, back-to-back outputs at 1 per cycle.
//  5 Simultaneous: pend_cnt=2, slot0 eligible, new req tag9 -> pend_cnt stays 2;
//    old slot1 moves to slot0, tag9 lands in slot1.
//  6 Flush/reset: flush with pend_cnt=3 and out_valid=1 -> next cycle pend_cnt=0, out_valid=0.
//    rst_n low mid-hsk -> all outputs at reset values.

Source files
------------

// File: rtl/srb_rd_sched.sv
// ---------------------------------------------------------------------------
// srb_rd_sched
//
// Read scheduler sitting directly downstream of the sparse read buffer (SRB).
// Read requests (SRB slot index + opaque consumer tag) are collected in a
// small collapsing pending queue. Each cycle the oldest pending request whose
// SRB entry is currently valid is issued to the SRB. Younger requests may
// therefore be serviced before older ones that are still waiting on their
// entry. The SRB answers combinationally in the same cycle. The answer is
// captured, together with the request's tag and index, into a 1-deep
// registered output stage.
//
// Ports
//   clk, rst_n        : single clock, asynchronous active-low reset
//   flush             : synchronous clear of pending queue and output stage
//   req_valid/ready   : request handshake
//   req_idx, req_tag  : SRB slot to read and consumer tag
//   srb_r_req_*       : read request to the SRB (valid, idx, ready)
//   srb_r_rsp_*       : read response from the SRB (valid, data, ready)
//   srb_entry_valid   : per-slot valid bits of the SRB
//   out_valid/ready   : registered response handshake
//   out_data/tag/idx  : response data, tag and slot of the serviced request
//   pend_cnt          : number of occupied pending-queue slots
// ---------------------------------------------------------------------------
module srb_rd_sched #(
   parameter  int DATA_WIDTH = 32,
   parameter  int SRB_DEPTH  = 8,
   parameter  int TAG_W      = 4,
   parameter  int PQ_DEPTH   = 4,
   localparam int IDX_W      = $clog2(SRB_DEPTH),
   localparam int CNT_W      = $clog2(PQ_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [IDX_W-1:0]      req_idx,
   input  logic [TAG_W-1:0]      req_tag,
   output logic                  srb_r_req_valid,
   output logic [IDX_W-1:0]      srb_r_req_idx,
   input  logic                  srb_r_req_ready,
   input  logic                  srb_r_rsp_valid,
   input  logic [DATA_WIDTH-1:0] srb_r_rsp_data,
   output logic                  srb_r_rsp_ready,
   input  logic [SRB_DEPTH-1:0]  srb_entry_valid,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [TAG_W-1:0]      out_tag,
   output logic [IDX_W-1:0]      out_idx,
   output logic [CNT_W-1:0]      pend_cnt
);

   localparam int SEL_W = (PQ_DEPTH > 1) ? $clog2(PQ_DEPTH) : 1;

   // Pending queue storage. Slot 0 is the oldest; occupied slots are always
   // the contiguous range 0..r_cnt-1, so occupancy is derived from the count.
   logic [IDX_W-1:0]      r_pqIdx [PQ_DEPTH];
   logic [TAG_W-1:0]      r_pqTag [PQ_DEPTH];
   logic [CNT_W-1:0]      r_cnt;

   // Output stage
   logic                  r_outValid;
   logic [DATA_WIDTH-1:0] r_outData;
   logic [TAG_W-1:0]      r_outTag;
   logic [IDX_W-1:0]      r_outIdx;

   logic [PQ_DEPTH-1:0]   w_elig;
   logic                  w_anyElig;
   logic [SEL_W-1:0]      w_sel;
   logic [IDX_W-1:0]      w_selIdx;
   logic [TAG_W-1:0]      w_selTag;
   logic                  w_reqReady;
   logic                  w_rspReady;
   logic                  w_enq;
   logic                  w_hsk;
   logic [CNT_W-1:0]      w_wrPos;
   logic [CNT_W-1:0]      w_nxtCnt;
   logic [IDX_W-1:0]      w_nxtIdx [PQ_DEPTH];
   logic [TAG_W-1:0]      w_nxtTag [PQ_DEPTH];

   // A slot can issue only when it is occupied and the SRB currently holds
   // valid data for the slot index it names.
   always_comb begin : eligibility
      w_elig = '0;
      for (int k = 0; k < PQ_DEPTH; k++) begin
         w_elig[k] = (CNT_W'(k) < r_cnt) && srb_entry_valid[r_pqIdx[k]];
      end
   end

   // Fixed priority by age: scanning from the youngest down, the last hit
   // wins, which leaves the lowest (oldest) eligible slot selected.
   always_comb begin : pickOldest
      w_anyElig = 1'b0;
      w_sel     = '0;
      w_selIdx  = '0;
      w_selTag  = '0;
      for (int k = PQ_DEPTH - 1; k >= 0; k--) begin
         if (w_elig[k]) begin
            w_anyElig = 1'b1;
            w_sel     = SEL_W'(k);
            w_selIdx  = r_pqIdx[k];
            w_selTag  = r_pqTag[k];
         end
      end
   end

   // Handshake terms. The same-cycle dequeue is deliberately not credited to
   // req_ready so the ready path does not depend on the SRB response.
   always_comb begin : handshakes
      w_reqReady = (r_cnt < CNT_W'(PQ_DEPTH)) && !flush;
      w_rspReady = (!r_outValid || out_ready) && !flush;
      w_enq      = req_valid && w_reqReady;
      w_hsk      = w_anyElig && !flush && srb_r_req_ready &&
                   srb_r_rsp_valid && w_rspReady;
   end

   // Next queue contents: on a handshake every slot from the selected one
   // upward takes its younger neighbour. A new request lands just above the
   // last occupied slot after that collapse, keeping age order intact.
   always_comb begin : queueNext
      for (int k = 0; k < PQ_DEPTH; k++) begin
         w_nxtIdx[k] = r_pqIdx[k];
         w_nxtTag[k] = r_pqTag[k];
      end
      if (w_hsk) begin
         for (int k = 0; k < PQ_DEPTH - 1; k++) begin
            if (SEL_W'(k) >= w_sel) begin
               w_nxtIdx[k] = r_pqIdx[k+1];
               w_nxtTag[k] = r_pqTag[k+1];
            end
         end
      end
      w_wrPos = r_cnt - CNT_W'(w_hsk);
      for (int k = 0; k < PQ_DEPTH; k++) begin
         if (w_enq && (CNT_W'(k) == w_wrPos)) begin
            w_nxtIdx[k] = req_idx;
            w_nxtTag[k] = req_tag;
         end
      end
      w_nxtCnt = r_cnt + CNT_W'(w_enq) - CNT_W'(w_hsk);
   end

   // Pending queue registers. Flush only needs to clear the count; stale
   // slot contents beyond the count are never looked at.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         for (int k = 0; k < PQ_DEPTH; k++) begin
            r_pqIdx[k] <= '0;
            r_pqTag[k] <= '0;
         end
      end else if (flush) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_nxtCnt;
         for (int k = 0; k < PQ_DEPTH; k++) begin
            r_pqIdx[k] <= w_nxtIdx[k];
            r_pqTag[k] <= w_nxtTag[k];
         end
      end
   end

   // Output stage: a handshake always reloads it (possible because the SRB
   // response is only accepted when the stage is empty or draining), so a
   // response can be delivered every cycle. Data holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outTag   <= '0;
         r_outIdx   <= '0;
      end else if (flush) begin
         r_outValid <= 1'b0;
      end else if (w_hsk) begin
         r_outValid <= 1'b1;
         r_outData  <= srb_r_rsp_data;
         r_outTag   <= w_selTag;
         r_outIdx   <= w_selIdx;
      end else if (out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign req_ready       = w_reqReady;
   assign srb_r_req_valid = w_anyElig && !flush;
   assign srb_r_req_idx   = w_selIdx;
   assign srb_r_rsp_ready = w_rspReady;
   assign out_valid       = r_outValid;
   assign out_data        = r_outData;
   assign out_tag         = r_outTag;
   assign out_idx         = r_outIdx;
   assign pend_cnt        = r_cnt;

endmodule

// File: tb/tb_srb_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_srb_rd_sched
//
// Bench for srb_rd_sched. A combinational SRB is modelled here: entry valid
// bits and data live in bench arrays, and a read handshake clears the entry.
// The scheduler itself is modelled as a plain queue of {idx,tag} in age
// order plus a single output register, and every cycle the DUT outputs are
// compared against that model. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_srb_rd_sched;

   localparam int DW = 32;
   localparam int SD = 8;
   localparam int TW = 4;
   localparam int PD = 4;
   localparam int IW = 3;
   localparam int CW = 3;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [TW-1:0] tag;
   } pqEntry_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          req_valid;
   wire           req_ready;
   logic [IW-1:0] req_idx;
   logic [TW-1:0] req_tag;
   wire           srb_r_req_valid;
   wire  [IW-1:0] srb_r_req_idx;
   logic          srb_r_req_ready;
   wire           srb_r_rsp_valid;
   wire  [DW-1:0] srb_r_rsp_data;
   wire           srb_r_rsp_ready;
   logic [SD-1:0] srbValid;
   wire           out_valid;
   logic          out_ready;
   wire  [DW-1:0] out_data;
   wire  [TW-1:0] out_tag;
   wire  [IW-1:0] out_idx;
   wire  [CW-1:0] pend_cnt;

   logic [DW-1:0] srbData [SD];

   // Behavioural model state
   pqEntry_t      pq[$];
   bit            mOutValid;
   logic [DW-1:0] mOutData;
   logic [TW-1:0] mOutTag;
   logic [IW-1:0] mOutIdx;

   int checks = 0;
   int errors = 0;

   srb_rd_sched #(
      .DATA_WIDTH(DW), .SRB_DEPTH(SD), .TAG_W(TW), .PQ_DEPTH(PD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_idx(req_idx), .req_tag(req_tag),
      .srb_r_req_valid(srb_r_req_valid), .srb_r_req_idx(srb_r_req_idx),
      .srb_r_req_ready(srb_r_req_ready),
      .srb_r_rsp_valid(srb_r_rsp_valid), .srb_r_rsp_data(srb_r_rsp_data),
      .srb_r_rsp_ready(srb_r_rsp_ready),
      .srb_entry_valid(srbValid),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .out_idx(out_idx),
      .pend_cnt(pend_cnt)
   );

   // Combinational SRB: answers in the same cycle it is asked
   assign srb_r_rsp_valid = srb_r_req_valid & srb_r_req_ready;
   assign srb_r_rsp_data  = srbData[srb_r_req_idx];

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      pq.delete();
      mOutValid = 1'b0;
      mOutData  = '0;
      mOutTag   = '0;
      mOutIdx   = '0;
   endtask

   // One clock cycle: drive at the negedge, compare against the model 1 ns
   // later, let the edge happen, then advance the model and the SRB.
   task automatic applyStimulus(input bit rv, input logic [IW-1:0] ix,
                                input logic [TW-1:0] tg, input bit ordy,
                                input bit fl, input bit srdy);
      int            sel;
      bit            expReqReady, expIssue, expRspReady, hsk, enq;
      logic [DW-1:0] hData;
      req_valid       = rv;
      req_idx         = ix;
      req_tag         = tg;
      out_ready       = ordy;
      flush           = fl;
      srb_r_req_ready = srdy;
      #1;
      sel = -1;
      for (int k = 0; k < pq.size(); k++) begin
         if (srbValid[pq[k].idx]) begin
            sel = k;
            break;
         end
      end
      expReqReady = (pq.size() < PD) && !fl;
      expIssue    = (sel >= 0) && !fl;
      expRspReady = (!mOutValid || ordy) && !fl;
      hsk         = expIssue && srdy && expRspReady;
      enq         = rv && expReqReady;
      checkOutput("req_ready", 32'(req_ready), 32'(expReqReady));
      checkOutput("srb_r_req_valid", 32'(srb_r_req_valid), 32'(expIssue));
      if (expIssue) checkOutput("srb_r_req_idx", 32'(srb_r_req_idx), 32'(pq[sel].idx));
      checkOutput("srb_r_rsp_ready", 32'(srb_r_rsp_ready), 32'(expRspReady));
      checkOutput("out_valid", 32'(out_valid), 32'(mOutValid));
      if (mOutValid) begin
         checkOutput("out_data", out_data, mOutData);
         checkOutput("out_tag", 32'(out_tag), 32'(mOutTag));
         checkOutput("out_idx", 32'(out_idx), 32'(mOutIdx));
      end
      checkOutput("pend_cnt", 32'(pend_cnt), pq.size());
      hData = (sel >= 0) ? srbData[pq[sel].idx] : '0;
      @(posedge clk);
      #1;
      if (fl) begin
         pq.delete();
         mOutValid = 1'b0;
      end else begin
         if (hsk) begin
            mOutValid = 1'b1;
            mOutData  = hData;
            mOutTag   = pq[sel].tag;
            mOutIdx   = pq[sel].idx;
            srbValid[pq[sel].idx] = 1'b0;
            pq.delete(sel);
         end else if (ordy) begin
            mOutValid = 1'b0;
         end
         if (enq) pq.push_back('{idx: ix, tag: tg});
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      req_valid = 1'b0;
      req_idx = '0;
      req_tag = '0;
      out_ready = 1'b1;
      srb_r_req_ready = 1'b1;
      srbValid = '0;
      for (int i = 0; i < SD; i++) srbData[i] = 32'hA000_0000 | i;
      modelReset();
      #1;
      checkOutput("reset pend_cnt", 32'(pend_cnt), 0);
      checkOutput("reset out_valid", 32'(out_valid), 0);
      checkOutput("reset req_ready", 32'(req_ready), 1);
      checkOutput("reset srb_r_req_valid", 32'(srb_r_req_valid), 0);
      checkOutput("reset out_data", out_data, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic read: enqueue, issue one cycle later, output two cycles later
      srbValid = 8'b0000_1000;
      applyStimulus(1'b1, 3'd3, 4'd5, 1'b1, 1'b0, 1'b1);
      checkOutput("basic pend after enq", 32'(pend_cnt), 1);
      checkOutput("basic issue valid", 32'(srb_r_req_valid), 1);
      checkOutput("basic issue idx", 32'(srb_r_req_idx), 3);
      idle(1);
      checkOutput("basic out_valid", 32'(out_valid), 1);
      checkOutput("basic out_tag", 32'(out_tag), 5);
      checkOutput("basic out_data", out_data, 32'hA000_0003);
      checkOutput("basic pend after hsk", 32'(pend_cnt), 0);
      idle(1);

      // Out of order: the younger request's entry becomes valid first
      srbValid = '0;
      applyStimulus(1'b1, 3'd2, 4'd0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'd5, 4'd1, 1'b1, 1'b0, 1'b1);
      srbValid = 8'b0010_0000;
      idle(1);
      checkOutput("ooo first tag", 32'(out_tag), 1);
      checkOutput("ooo first idx", 32'(out_idx), 5);
      checkOutput("ooo pend", 32'(pend_cnt), 1);
      srbValid[2] = 1'b1;
      idle(1);
      checkOutput("ooo second tag", 32'(out_tag), 0);
      checkOutput("ooo pend empty", 32'(pend_cnt), 0);
      idle(1);

      // Full queue: fifth request is held until a slot frees
      srbValid = '0;
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, IW'(i), TW'(i + 8), 1'b1, 1'b0, 1'b1);
      checkOutput("full pend", 32'(pend_cnt), 4);
      checkOutput("full req_ready", 32'(req_ready), 0);
      applyStimulus(1'b1, 3'd4, 4'd7, 1'b1, 1'b0, 1'b1);
      checkOutput("full fifth held", 32'(pend_cnt), 4);
      srbValid[0] = 1'b1;
      applyStimulus(1'b1, 3'd4, 4'd7, 1'b1, 1'b0, 1'b1);
      checkOutput("full pend after hsk", 32'(pend_cnt), 3);
      checkOutput("full req_ready after hsk", 32'(req_ready), 1);
      applyStimulus(1'b1, 3'd4, 4'd7, 1'b1, 1'b0, 1'b1);
      checkOutput("full fifth accepted", 32'(pend_cnt), 4);
      srbValid = 8'h1F;
      idle(6);
      checkOutput("full drained", 32'(pend_cnt), 0);

      // Backpressure then back-to-back delivery
      srbValid = 8'b0000_0110;
      applyStimulus(1'b1, 3'd1, 4'd2, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'd2, 4'd3, 1'b0, 1'b0, 1'b1);
      checkOutput("bp out_tag", 32'(out_tag), 2);
      checkOutput("bp pend", 32'(pend_cnt), 1);
      checkOutput("bp rsp_ready low", 32'(srb_r_rsp_ready), 0);
      applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("bp data stable", out_data, 32'hA000_0001);
      checkOutput("bp tag stable", 32'(out_tag), 2);
      applyStimulus(1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1);
      checkOutput("bp b2b valid", 32'(out_valid), 1);
      checkOutput("bp b2b tag", 32'(out_tag), 3);
      checkOutput("bp b2b data", out_data, 32'hA000_0002);
      idle(1);

      // Simultaneous enqueue and dequeue keeps count and age order
      srbValid = '0;
      applyStimulus(1'b1, 3'd4, 4'd1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'd6, 4'd2, 1'b1, 1'b0, 1'b1);
      srbValid[4] = 1'b1;
      applyStimulus(1'b1, 3'd7, 4'd9, 1'b1, 1'b0, 1'b1);
      checkOutput("simul pend", 32'(pend_cnt), 2);
      checkOutput("simul out_tag", 32'(out_tag), 1);
      srbValid = srbValid | 8'b1100_0000;
      idle(1);
      checkOutput("simul slot0 tag", 32'(out_tag), 2);
      idle(1);
      checkOutput("simul slot1 tag", 32'(out_tag), 9);
      idle(1);

      // Flush with a populated queue and a full output stage
      srbValid = 8'b0010_0000;
      applyStimulus(1'b1, 3'd5, 4'd4, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'd0, 4'd1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'd1, 4'd2, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'd2, 4'd3, 1'b0, 1'b0, 1'b1);
      checkOutput("flush pre pend", 32'(pend_cnt), 3);
      checkOutput("flush pre out_valid", 32'(out_valid), 1);
      applyStimulus(1'b1, 3'd3, 4'd3, 1'b0, 1'b1, 1'b1);
      checkOutput("flush pend", 32'(pend_cnt), 0);
      checkOutput("flush out_valid", 32'(out_valid), 0);

      // Asynchronous reset in the middle of a handshake
      srbValid[3] = 1'b1;
      applyStimulus(1'b1, 3'd3, 4'd8, 1'b1, 1'b0, 1'b1);
      req_valid = 1'b0;
      out_ready = 1'b1;
      srb_r_req_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst pend_cnt", 32'(pend_cnt), 0);
      checkOutput("rst out_valid", 32'(out_valid), 0);
      checkOutput("rst srb_r_req_valid", 32'(srb_r_req_valid), 0);
      checkOutput("rst req_ready", 32'(req_ready), 1);
      checkOutput("rst out_data", out_data, 0);
      checkOutput("rst out_tag", 32'(out_tag), 0);
      modelReset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the model
      srbValid = '0;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < SD; i++) begin
            if (!srbValid[i] && ($urandom_range(0, 5) == 0)) begin
               srbValid[i] = 1'b1;
               srbData[i]  = $urandom;
            end
         end
         applyStimulus($urandom_range(0, 2) != 0, IW'($urandom_range(0, SD - 1)),
                       TW'($urandom), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 40) == 0, $urandom_range(0, 5) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
